// File: rtl/pc_fetch_controller.sv
// Run-control sequencer for the vector CPU front end: fetches instructions over a req/ack
// handshake, issues them to the decoder and advances the PC from the pc_control_unit.
module pc_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Stall,
  input  logic             EndFlag,
  input  logic [31:0]      PCNext,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      Instr,
  output logic             InstrValid,
  output logic             PCEn,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  icnt_q, icnt_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    wait_d     = wait_q;
    done_d     = done_q;
    error_d    = error_q;
    cyc_d      = cyc_q;
    icnt_d     = icnt_q;

    if (state_q == FETCH || state_q == ISSUE) begin
      cyc_d = sat_inc(cyc_q);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          fetch_pc_d = RESET_PC;
          wait_d     = '0;
          cyc_d      = '0;
          icnt_d     = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
        end
      end
      FETCH: begin
        // An ack in the timeout cycle still completes the fetch.
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ISSUE: begin
        if (!Stall) begin
          icnt_d = sat_inc(icnt_q);
          if (EndFlag) begin
            done_d  = 1'b1;
            state_d = HALT;
          end else begin
            fetch_pc_d = PCNext;
            wait_d     = '0;
            state_d    = FETCH;
          end
        end
      end
      HALT: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_d   = (state_d == FETCH);
    valid_d = (state_d == ISSUE);
    busy_d  = req_d | valid_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      instr_q    <= '0;
      wait_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cyc_q      <= '0;
      icnt_q     <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      wait_q     <= wait_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cyc_q      <= cyc_d;
      icnt_q     <= icnt_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  // Accept pulse must track Stall/EndFlag in the same cycle, so it stays combinational.
  assign PCEn       = (state_q == ISSUE) && !Stall && !EndFlag;
  assign imem_req   = req_q;
  assign imem_addr  = fetch_pc_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Error      = error_q;
  assign CycleCount = cyc_q;
  assign InstrCount = icnt_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller: a small memory responder plus queues of expected
// fetch addresses and instructions.
module tb_pc_fetch_controller;

  logic        clk = 1'b0;
  logic        reset, start, Stall, EndFlag, imem_ack;
  logic [31:0] PCNext, imem_rdata;
  logic        imem_req, InstrValid, PCEn, Busy, Done, Error;
  logic [31:0] imem_addr, Instr;
  logic [15:0] CycleCount, InstrCount;

  pc_fetch_controller dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .Stall      (Stall),
    .EndFlag    (EndFlag),
    .PCNext     (PCNext),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .PCEn       (PCEn),
    .Busy       (Busy),
    .Done       (Done),
    .Error      (Error),
    .CycleCount (CycleCount),
    .InstrCount (InstrCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_icnt = 0;
  int exp_cyc = 0;
  bit in_run = 1'b0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    bit was_run;
    was_run = in_run;
    @(posedge clk);
    #1;
    if (was_run) exp_cyc++;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("req_seen", 32'(ok), 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] rdata, input int delay);
    bit          ok;
    logic [31:0] ea;
    wait_req(ok);
    if (!ok) return;
    ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hdead_beef;
    chk("imem_addr", imem_addr, ea);
    for (int i = 0; i < delay; i++) begin
      chk("valid_in_fetch", 32'(InstrValid), 32'd0);
      tick();
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", imem_addr, ea);
      chk("no_early_err", 32'(Error), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    exp_instr_q.push_back(rdata);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("req_drop", 32'(imem_req), 32'd0);
    chk("valid_issue", 32'(InstrValid), 32'd1);
    chk("instr", Instr, (exp_instr_q.size() != 0) ? exp_instr_q.pop_front() : 32'hdead_beef);
  endtask

  task automatic issue(input logic [31:0] pcnext, input int stalls, input bit endf);
    logic [31:0] held;
    held = Instr;
    for (int i = 0; i < stalls; i++) begin
      Stall = 1'b1;
      #1;
      chk("pcen_stall", 32'(PCEn), 32'd0);
      tick();
      chk("valid_stall", 32'(InstrValid), 32'd1);
      chk("instr_stable", Instr, held);
    end
    Stall   = 1'b0;
    EndFlag = endf;
    PCNext  = pcnext;
    #1;
    chk("pcen", 32'(PCEn), 32'(!endf));
    chk("valid_accept", 32'(InstrValid), 32'd1);
    if (!endf) exp_addr_q.push_back(pcnext);
    exp_icnt++;
    tick();
    EndFlag = 1'b0;
    chk("instr_count", 32'(InstrCount), 32'(exp_icnt));
    chk("pcen_one_shot", 32'(PCEn), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; Stall = 1'b0; EndFlag = 1'b0;
    PCNext = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;

    // Reset held with start asserted: nothing may be requested.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_req", 32'(imem_req), 32'd0);
    end
    reset = 1'b1;
    start = 1'b0;
    tick();
    chk("rst_req2", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(InstrValid), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_pcen", 32'(PCEn), 32'd0);
    chk("rst_cyc", 32'(CycleCount), 32'd0);
    chk("rst_icnt", 32'(InstrCount), 32'd0);

    // Normal run; start dropped mid-run is ignored.
    exp_addr_q.push_back(32'h0);
    start = 1'b1;
    tick();
    in_run  = 1'b1;
    exp_cyc = 0;
    start   = 1'b0;
    chk("busy_run", 32'(Busy), 32'd1);
    do_fetch(32'h6500_0007, 0);
    issue(32'h4, 0, 1'b0);
    do_fetch(32'hC000_0050, 0);
    issue(32'h50, 0, 1'b0);
    do_fetch(32'hD000_013C, 0);
    issue(32'h13C, 0, 1'b0);
    do_fetch(32'h1234_5678, 2);
    issue(32'h200, 3, 1'b0);
    // Ack in the final allowed wait cycle must win over the timeout.
    do_fetch(32'h0BAD_F00D, 14);
    chk("boundary_no_err", 32'(Error), 32'd0);
    issue(32'h204, 0, 1'b0);
    start = 1'b1;
    do_fetch(32'hFFFF_0001, 1);
    issue(32'h208, 0, 1'b1);
    in_run = 1'b0;
    chk("halt_done", 32'(Done), 32'd1);
    chk("halt_error", 32'(Error), 32'd0);
    chk("halt_busy", 32'(Busy), 32'd0);
    chk("halt_valid", 32'(InstrValid), 32'd0);
    chk("halt_cyc", 32'(CycleCount), 32'(exp_cyc));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_done_hold", 32'(Done), 32'd1);
    end
    start = 1'b0;
    tick();
    chk("idle_done_hold", 32'(Done), 32'd1);
    chk("idle_busy", 32'(Busy), 32'd0);

    // Restart, then withhold ack until timeout.
    exp_addr_q.push_back(32'h0);
    start = 1'b1;
    tick();
    in_run   = 1'b1;
    exp_cyc  = 0;
    exp_icnt = 0;
    start    = 1'b0;
    chk("restart_done", 32'(Done), 32'd0);
    chk("restart_icnt", 32'(InstrCount), 32'd0);
    chk("restart_cyc", 32'(CycleCount), 32'd0);
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, exp_addr_q.pop_front());
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("to_wait_err", 32'(Error), 32'd0);
      chk("to_wait_req", 32'(imem_req), 32'd1);
    end
    tick();
    in_run = 1'b0;
    chk("to_error", 32'(Error), 32'd1);
    chk("to_done", 32'(Done), 32'd0);
    chk("to_busy", 32'(Busy), 32'd0);
    chk("to_req", 32'(imem_req), 32'd0);
    chk("to_cyc", 32'(CycleCount), 32'(exp_cyc));
    tick();
    chk("to_err_hold", 32'(Error), 32'd1);

    // Reset during FETCH; a late ack must be ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_req", 32'(imem_req), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_CAFE;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("late_ack_valid", 32'(InstrValid), 32'd0);
    chk("late_ack_instr", Instr, 32'd0);
    chk("late_ack_req", 32'(imem_req), 32'd0);
    chk("late_ack_err", 32'(Error), 32'd0);
    tick();
    chk("post_rst_busy", 32'(Busy), 32'd0);
    chk("post_rst_cyc", 32'(CycleCount), 32'd0);
    chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_controller.md
Name: pc_fetch_controller

Overview:
Run-control sequencer for the vector CPU front end. It starts execution on `start`, fetches instructions from instruction memory over a req/ack handshake and presents each instruction to the decoder and pc_control_unit. It advances the PC using the pc_control_unit's `PCNext`, holds on datapath stalls and halts on `EndFlag` or on a memory timeout.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after `start`
TIMEOUT, 15, max cycles waiting for `imem_ack` before error halt
CNT_W, 16, width of cycle and instruction counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
start  input  1  level; sampled in IDLE to begin execution
Stall  input  1  datapath busy; hold current instruction
EndFlag  input  1  from pc_control_unit; current instruction is end-of-program
PCNext  input  32  from pc_control_unit; next PC for current Instr (combinational)
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, stable while imem_req=1
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
Instr  output  32  registered current instruction
InstrValid  output  1  Instr valid for issue
PCEn  output  1  one-cycle pulse: instruction accepted, PC advances
Busy  output  1  FETCH or ISSUE state
Done  output  1  normal halt
Error  output  1  timeout halt
CycleCount  output  CNT_W  cycles spent in FETCH+ISSUE, saturating
InstrCount  output  CNT_W  instructions accepted (PCEn pulses), saturating

Behaviour:
- States: IDLE, FETCH, ISSUE, HALT. All outputs registered except `PCEn`, which is combinational from state, `Stall` and `EndFlag`.
- Reset (reset=0 at posedge): state=IDLE; fetch_pc=RESET_PC; Instr=0; all 1-bit outputs 0; counters 0. Reset takes effect at that edge in any state. A mid-fetch request is dropped; late acks after reset are ignored.
- IDLE: `start`=1 goes to FETCH. Load fetch_pc=RESET_PC, clear counters, Done and Error.
- FETCH:
  - `imem_req`=1, `imem_addr`=fetch_pc, both held until ack.
  - The wait counter increments each cycle without ack.
  - On `imem_ack`: Instr<=imem_rdata, go to ISSUE.
  - If the wait counter reaches TIMEOUT with no ack: Error<=1, go to HALT.
  - An ack in the same cycle as the timeout wins; no error.
- ISSUE:
  - `InstrValid`=1. `imem_req`=0.
  - If `Stall`=1: remain in ISSUE, Instr stable, PCEn=0.
  - If `Stall`=0 and `EndFlag`=0: PCEn=1 for one cycle; fetch_pc<=PCNext; InstrCount++; go to FETCH.
  - If `Stall`=0 and `EndFlag`=1: PCEn=0; InstrCount++; Done<=1; go to HALT.
- HALT: Busy=0, imem_req=0, InstrValid=0. Done/Error held. When `start`=0, go to IDLE; Done/Error stay until the next start.
- `start` deasserted during FETCH/ISSUE is ignored.
- Minimum throughput with a 1-cycle ack memory: one instruction per 2 cycles (FETCH, ISSUE).
- Counters saturate at all-ones; no wrap.
- The wait counter clears on entry to FETCH.
- fetch_pc is taken verbatim from PCNext; no alignment checking.

Test Plan:
1. reset=0 for 3 cycles with start=1, then reset=1 and start=0 → all outputs 0, imem_req never asserted.
2. RESET_PC=0; start=1; memory acks 1 cycle after req with 32'h65000007; PCNext=32'h4 → imem_addr=0, InstrValid 1 cycle, one PCEn pulse, next imem_addr=32'h4, InstrCount=1.
3. Instr 32'hC0000050 with PCNext=32'h50 → next imem_addr=32'h50. Repeat with 32'hD000013C / PCNext=32'h13C → imem_addr=32'h13C.
4. Stall=1 for 3 cycles in ISSUE → InstrValid high 4 cycles, Instr unchanged, exactly one PCEn on release.
5. EndFlag=1 on fetched instruction → Done=1, PCEn=0, no further imem_req, Busy=0. Then start=0 → IDLE; start=1 → fetch restarts at imem_addr=0, counters cleared.
6. Withhold imem_ack 15 cycles → Error=1, HALT. Separately, reset=0 mid-FETCH → imem_req=0 after that edge, state IDLE; ack arriving on the next cycle is ignored.
